// File: rtl/apu_frame_sequencer_gen2_pkg.sv
// Shared constants and types for the APU frame sequencer: step thresholds,
// counter width and the 4-step/5-step mode encoding.
package apu_pkg;

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DLY_W  = 3;

   typedef logic [CNT_W-1:0] frame_cnt_t;

   typedef enum logic {
      FRAME_4STEP = 1'b0,
      FRAME_5STEP = 1'b1
   } frame_mode_t;

   localparam frame_cnt_t Q1_CYC = frame_cnt_t'(7456);
   localparam frame_cnt_t Q2_CYC = frame_cnt_t'(14912);
   localparam frame_cnt_t Q3_CYC = frame_cnt_t'(22370);
   localparam frame_cnt_t M0_END = frame_cnt_t'(29829);
   localparam frame_cnt_t M1_END = frame_cnt_t'(37281);

   // Derived decode points: IRQ window start and the final step of each mode
   localparam frame_cnt_t M0_IRQ_CYC  = frame_cnt_t'(M0_END - frame_cnt_t'(2));
   localparam frame_cnt_t M0_STEP_CYC = frame_cnt_t'(M0_END - frame_cnt_t'(1));
   localparam frame_cnt_t M1_STEP_CYC = frame_cnt_t'(M1_END - frame_cnt_t'(1));

endpackage

// File: rtl/apu_frame_sequencer_gen2_if.sv
// CPU-side and channel-side signals of the frame sequencer, bundled as one bus.
interface apu_frame_sequencer_gen2_if;
   import apu_pkg::*;

   logic              cpu_clk;
   logic              wren_4017;
   logic [DATA_W-1:0] from_cpu;
   logic              status_rd;
   logic              e_pulse;
   logic              l_pulse;
   logic              frame_irq;
   logic              mode_out;

   modport master (
      output cpu_clk, wren_4017, from_cpu, status_rd,
      input  e_pulse, l_pulse, frame_irq, mode_out
   );

   modport slave (
      input  cpu_clk, wren_4017, from_cpu, status_rd,
      output e_pulse, l_pulse, frame_irq, mode_out
   );

endinterface

// File: rtl/apu_frame_sequencer_gen2_reset_delay.sv
// Pending sequencer reset after a $4017 write: 3 or 4 CPU cycles depending on
// the parity at the write; a new write reloads the delay.
module apu_frame_reset_delay
   import apu_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic cpu_clk,
   input  logic load,
   input  logic parity,
   output logic expire_c
);

   logic [DLY_W-1:0] dly_q;

   // Zero means idle; the cycle that would step 1 -> 0 is the expiry
   always_ff @(posedge clk) begin
      if (rst) begin
         dly_q <= '0;
      end else if (load) begin
         dly_q <= parity ? DLY_W'(4) : DLY_W'(3);
      end else if (cpu_clk && (dly_q != '0)) begin
         dly_q <= dly_q - DLY_W'(1);
      end
   end

   assign expire_c = cpu_clk && !load && (dly_q == DLY_W'(1));

endmodule

// File: rtl/apu_frame_sequencer_gen2.sv
// APU frame counter: quarter/half-frame strobes, $4017 mode/inhibit register,
// delayed sequencer reset and the frame IRQ flag.
module apu_frame_sequencer_gen2
   import apu_pkg::*;
(
   input logic                       clk,
   input logic                       rst,
   apu_frame_sequencer_gen2_if.slave bus
);

   frame_cnt_t  cnt_q;
   frame_mode_t mode_q;
   logic        irq_inhibit_q;
   logic        irq_q;
   logic        parity_q;
   logic        e_q;
   logic        l_q;

   frame_cnt_t  cnt_nxt_c;
   frame_cnt_t  end_val_c;
   logic        e_nxt_c;
   logic        l_nxt_c;
   logic        irq_set_c;
   logic        expire_c;
   logic        unused_from_cpu;

   assign unused_from_cpu = |bus.from_cpu[5:0];

   apu_frame_reset_delay u_reset_delay (
      .clk      (clk),
      .rst      (rst),
      .cpu_clk  (bus.cpu_clk),
      .load     (bus.wren_4017),
      .parity   (parity_q),
      .expire_c (expire_c)
   );

   // Step decode on the pre-increment count; a reset expiry overrides it
   always_comb begin
      cnt_nxt_c = cnt_q;
      e_nxt_c   = 1'b0;
      l_nxt_c   = 1'b0;
      irq_set_c = 1'b0;
      end_val_c = (mode_q == FRAME_5STEP) ? M1_END : M0_END;
      if (bus.cpu_clk) begin
         if (expire_c) begin
            cnt_nxt_c = '0;
            e_nxt_c   = (mode_q == FRAME_5STEP);
            l_nxt_c   = (mode_q == FRAME_5STEP);
         end else begin
            cnt_nxt_c = (cnt_q >= end_val_c) ? '0 : cnt_q + frame_cnt_t'(1);
            if ((cnt_q == Q1_CYC) || (cnt_q == Q3_CYC)) begin
               e_nxt_c = 1'b1;
            end
            if (cnt_q == Q2_CYC) begin
               e_nxt_c = 1'b1;
               l_nxt_c = 1'b1;
            end
            if (mode_q == FRAME_4STEP) begin
               if (cnt_q == M0_STEP_CYC) begin
                  e_nxt_c = 1'b1;
                  l_nxt_c = 1'b1;
               end
               if ((cnt_q == M0_IRQ_CYC) || (cnt_q == M0_STEP_CYC) || (cnt_q == M0_END)) begin
                  irq_set_c = !irq_inhibit_q;
               end
            end else if (cnt_q == M1_STEP_CYC) begin
               e_nxt_c = 1'b1;
               l_nxt_c = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         mode_q        <= FRAME_4STEP;
         irq_inhibit_q <= 1'b0;
         irq_q         <= 1'b0;
         parity_q      <= 1'b0;
         e_q           <= 1'b0;
         l_q           <= 1'b0;
      end else begin
         cnt_q <= cnt_nxt_c;
         e_q   <= e_nxt_c;
         l_q   <= l_nxt_c;
         if (bus.cpu_clk) begin
            parity_q <= !parity_q;
         end
         if (bus.wren_4017) begin
            mode_q        <= frame_mode_t'(bus.from_cpu[7]);
            irq_inhibit_q <= bus.from_cpu[6];
         end
         // Inhibit write beats a set; a set beats a $4015 read
         if (bus.wren_4017 && bus.from_cpu[6]) begin
            irq_q <= 1'b0;
         end else if (irq_set_c) begin
            irq_q <= 1'b1;
         end else if (bus.status_rd) begin
            irq_q <= 1'b0;
         end
      end
   end

   assign bus.e_pulse   = e_q;
   assign bus.l_pulse   = l_q;
   assign bus.frame_irq = irq_q;
   assign bus.mode_out  = (mode_q == FRAME_5STEP);

endmodule

// File: tb/tb_apu_frame_sequencer_gen2.sv
// Directed bench for apu_frame_sequencer_gen2: step timing in both modes,
// delayed reset, IRQ set/clear priorities and synchronous reset.
module tb_apu_frame_sequencer_gen2;

   logic clk;
   logic rst;

   apu_frame_sequencer_gen2_if bif ();

   apu_frame_sequencer_gen2 dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;
   bit par;
   int e_pos[$];
   int l_pos[$];
   int exp_e[$];
   int exp_l[$];
   bit irq_any;
   int stray;

   function automatic int first_of(input int q[$]);
      return (q.size() > 0) ? q[0] : -1;
   endfunction

   function automatic int last_of(input int q[$]);
      return (q.size() > 0) ? q[q.size()-1] : -1;
   endfunction

   task automatic write_4017(input logic [7:0] data);
      bif.wren_4017 = 1'b1;
      bif.from_cpu  = data;
      @(posedge clk); #1;
      bif.wren_4017 = 1'b0;
      bif.from_cpu  = 8'h00;
   endtask

   // n CPU cycles, each followed by gap idle clocks; records pulse positions
   task automatic run_cpu(input int n, input int gap);
      e_pos.delete();
      l_pos.delete();
      irq_any = 1'b0;
      stray   = 0;
      for (int i = 0; i < n; i++) begin
         bif.cpu_clk = 1'b1;
         @(posedge clk); #1;
         bif.cpu_clk = 1'b0;
         par = !par;
         if (bif.e_pulse === 1'b1) e_pos.push_back(i);
         if (bif.l_pulse === 1'b1) l_pos.push_back(i);
         if (bif.frame_irq !== 1'b0) irq_any = 1'b1;
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            if ((bif.e_pulse !== 1'b0) || (bif.l_pulse !== 1'b0)) stray++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bif.cpu_clk   = 1'b1;
      bif.wren_4017 = 1'b1;
      bif.from_cpu  = 8'hC0;
      bif.status_rd = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bif.cpu_clk   = 1'b0;
      bif.wren_4017 = 1'b0;
      bif.from_cpu  = 8'h00;
      bif.status_rd = 1'b0;
      rst = 1'b0;
      par = 1'b0;
      total++; if (bif.e_pulse !== 1'b0) begin bad++; $display("FAIL reset_e got %b want 0", bif.e_pulse); end
      total++; if (bif.l_pulse !== 1'b0) begin bad++; $display("FAIL reset_l got %b want 0", bif.l_pulse); end
      total++; if (bif.frame_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got %b want 0", bif.frame_irq); end
      total++; if (bif.mode_out !== 1'b0) begin bad++; $display("FAIL reset_mode got %b want 0", bif.mode_out); end
   endtask

   task automatic test_mode0_free_run();
      run_cpu(29827, 0);
      exp_e = '{7456, 14912, 22370};
      exp_l = '{14912};
      total++; if (e_pos != exp_e) begin bad++; $display("FAIL m0_e_pos got n=%0d first=%0d last=%0d want %p", e_pos.size(), first_of(e_pos), last_of(e_pos), exp_e); end
      total++; if (l_pos != exp_l) begin bad++; $display("FAIL m0_l_pos got n=%0d first=%0d last=%0d want %p", l_pos.size(), first_of(l_pos), last_of(l_pos), exp_l); end
      total++; if (irq_any !== 1'b0) begin bad++; $display("FAIL m0_irq_early got %b want 0", irq_any); end
   endtask

   task automatic test_irq_status();
      bif.cpu_clk = 1'b1;
      @(posedge clk); #1;
      bif.cpu_clk = 1'b0;
      par = !par;
      total++; if (bif.frame_irq !== 1'b1) begin bad++; $display("FAIL irq_rise_29827 got %b want 1", bif.frame_irq); end
      total++; if (bif.e_pulse !== 1'b0) begin bad++; $display("FAIL e_at_29827 got %b want 0", bif.e_pulse); end
      bif.status_rd = 1'b1;
      @(posedge clk); #1;
      bif.status_rd = 1'b0;
      total++; if (bif.frame_irq !== 1'b0) begin bad++; $display("FAIL status_clear got %b want 0", bif.frame_irq); end
      bif.cpu_clk   = 1'b1;
      bif.status_rd = 1'b1;
      @(posedge clk); #1;
      bif.cpu_clk   = 1'b0;
      bif.status_rd = 1'b0;
      par = !par;
      total++; if (bif.frame_irq !== 1'b1) begin bad++; $display("FAIL set_beats_status got %b want 1", bif.frame_irq); end
      total++; if ({bif.e_pulse, bif.l_pulse} !== 2'b11) begin bad++; $display("FAIL el_at_29828 got %b want 11", {bif.e_pulse, bif.l_pulse}); end
   endtask

   task automatic test_inhibit_coincident();
      // $4017=0x40 on the cnt 29829 cycle, parity 1 -> 4-cycle delay
      bif.cpu_clk   = 1'b1;
      bif.wren_4017 = 1'b1;
      bif.from_cpu  = 8'h40;
      @(posedge clk); #1;
      bif.cpu_clk   = 1'b0;
      bif.wren_4017 = 1'b0;
      bif.from_cpu  = 8'h00;
      par = !par;
      total++; if (bif.frame_irq !== 1'b0) begin bad++; $display("FAIL inhibit_beats_set got %b want 0", bif.frame_irq); end
      total++; if (bif.mode_out !== 1'b0) begin bad++; $display("FAIL inhibit_mode got %b want 0", bif.mode_out); end
      total++; if ({bif.e_pulse, bif.l_pulse} !== 2'b00) begin bad++; $display("FAIL el_at_29829 got %b want 00", {bif.e_pulse, bif.l_pulse}); end
   endtask

   task automatic test_mode0_delay();
      // Expiry at local 3 with no pulses, then cnt 7456 at local 7460
      run_cpu(14004, 0);
      exp_e = '{7460};
      total++; if (e_pos != exp_e) begin bad++; $display("FAIL m0_delay_e got n=%0d first=%0d last=%0d want %p", e_pos.size(), first_of(e_pos), last_of(e_pos), exp_e); end
      total++; if (l_pos.size() != 0) begin bad++; $display("FAIL m0_delay_l got n=%0d first=%0d want none", l_pos.size(), first_of(l_pos)); end
      total++; if (irq_any !== 1'b0) begin bad++; $display("FAIL inhibit_hold got %b want 0", irq_any); end
   endtask

   task automatic test_rst_pending();
      write_4017(8'h80);
      total++; if (bif.mode_out !== 1'b1) begin bad++; $display("FAIL rst_pre_mode got %b want 1", bif.mode_out); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      par = 1'b0;
      total++; if (bif.mode_out !== 1'b0) begin bad++; $display("FAIL rst_mode got %b want 0", bif.mode_out); end
      total++; if ({bif.e_pulse, bif.l_pulse, bif.frame_irq} !== 3'b000) begin bad++; $display("FAIL rst_outs got %b want 000", {bif.e_pulse, bif.l_pulse, bif.frame_irq}); end
      run_cpu(7457, 0);
      exp_e = '{7456};
      total++; if (e_pos != exp_e) begin bad++; $display("FAIL rst_e_pos got n=%0d first=%0d last=%0d want %p", e_pos.size(), first_of(e_pos), last_of(e_pos), exp_e); end
      total++; if (l_pos.size() != 0) begin bad++; $display("FAIL rst_l_pos got n=%0d first=%0d want none", l_pos.size(), first_of(l_pos)); end
   endtask

   task automatic test_back_to_back_write();
      run_cpu(1, 0);
      total++; if (par !== 1'b0) begin bad++; $display("FAIL b2b_parity_setup got %b want 0", par); end
      write_4017(8'h80);
      bif.cpu_clk = 1'b1;
      @(posedge clk); #1;
      bif.cpu_clk = 1'b0;
      par = !par;
      total++; if (bif.e_pulse !== 1'b0) begin bad++; $display("FAIL b2b_early_e got %b want 0", bif.e_pulse); end
      @(posedge clk); #1;
      // Reload at parity 1: 4 cycles, single e+l at local 3
      write_4017(8'h80);
      run_cpu(4, 1);
      exp_e = '{3};
      exp_l = '{3};
      total++; if (e_pos != exp_e) begin bad++; $display("FAIL b2b_e_pos got n=%0d first=%0d last=%0d want %p", e_pos.size(), first_of(e_pos), last_of(e_pos), exp_e); end
      total++; if (l_pos != exp_l) begin bad++; $display("FAIL b2b_l_pos got n=%0d first=%0d last=%0d want %p", l_pos.size(), first_of(l_pos), last_of(l_pos), exp_l); end
      total++; if (stray != 0) begin bad++; $display("FAIL b2b_held_pulse got %0d want 0", stray); end
   endtask

   task automatic test_mode1_frame();
      run_cpu(1, 0);
      total++; if (e_pos.size() != 0) begin bad++; $display("FAIL m1_pad_e got n=%0d want 0", e_pos.size()); end
      write_4017(8'h80);
      run_cpu(3, 1);
      exp_e = '{2};
      exp_l = '{2};
      total++; if (e_pos != exp_e) begin bad++; $display("FAIL m1_expiry_e got n=%0d first=%0d want %p", e_pos.size(), first_of(e_pos), exp_e); end
      total++; if (l_pos != exp_l) begin bad++; $display("FAIL m1_expiry_l got n=%0d first=%0d want %p", l_pos.size(), first_of(l_pos), exp_l); end
      total++; if (stray != 0) begin bad++; $display("FAIL m1_held_pulse got %0d want 0", stray); end
      run_cpu(37282, 0);
      exp_e = '{7456, 14912, 22370, 37280};
      exp_l = '{14912, 37280};
      total++; if (e_pos != exp_e) begin bad++; $display("FAIL m1_e_pos got n=%0d first=%0d last=%0d want %p", e_pos.size(), first_of(e_pos), last_of(e_pos), exp_e); end
      total++; if (l_pos != exp_l) begin bad++; $display("FAIL m1_l_pos got n=%0d first=%0d last=%0d want %p", l_pos.size(), first_of(l_pos), last_of(l_pos), exp_l); end
      total++; if (irq_any !== 1'b0) begin bad++; $display("FAIL m1_irq got %b want 0", irq_any); end
      total++; if (bif.mode_out !== 1'b1) begin bad++; $display("FAIL m1_mode got %b want 1", bif.mode_out); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bif.cpu_clk   = 1'b0;
      bif.wren_4017 = 1'b0;
      bif.from_cpu  = 8'h00;
      bif.status_rd = 1'b0;
      test_reset();
      test_mode0_free_run();
      test_irq_status();
      test_inhibit_coincident();
      test_mode0_delay();
      test_rst_pending();
      test_back_to_back_write();
      test_mode1_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apu_frame_sequencer_gen2.md
Name: apu_frame_sequencer_gen2

Overview:
- APU frame counter/scheduler driving the channel envelope/linear-counter and length-counter timing. Produces the 1-clk `e_pulse` (quarter frame) and `l_pulse` (half frame) strobes consumed by apu_triangle_gen2 and the sibling pulse/noise channels.
- Owns the $4017 mode/IRQ-inhibit register, the delayed sequencer reset after a $4017 write, and the frame IRQ flag cleared by $4015 reads.

Parameters:
- Q1_CYC, 7456, counter value giving first quarter-frame step
- Q2_CYC, 14912, counter value giving second step (quarter + half)
- Q3_CYC, 22370, counter value giving third step (quarter)
- M0_END, 29829, mode-0 final counter value; step 4 at M0_END-1
- M1_END, 37281, mode-1 final counter value; step 5 at M1_END-1
- CNT_W, 16, frame counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_clk  in  1  1-clk pulse per CPU cycle
- wren_4017  in  1  write strobe for $4017 (1 clk)
- from_cpu  in  8  write data; [7]=mode (0: 4-step, 1: 5-step), [6]=IRQ inhibit
- status_rd  in  1  1-clk strobe on CPU read of $4015
- e_pulse  out  1  quarter-frame strobe, 1 clk, coincident with a cpu_clk clk
- l_pulse  out  1  half-frame strobe, 1 clk, coincident with a cpu_clk clk
- frame_irq  out  1  frame IRQ flag (level)
- mode_out  out  1  current mode bit, for debug/status

Behaviour:
- One clock `clk`; reset `rst` is synchronous, active-high. All state changes happen on the posedge of `clk`. Counter/step logic advances only in clks where cpu_clk=1.
- Reset values: cnt=0, mode=0, irq_inhibit=0, frame_irq=0, parity=0, no reset pending, e_pulse=0, l_pulse=0.
- Counter: on each cpu_clk, compare the current cnt (before update), then do cnt<=cnt+1. Exception: when the end value is reached, cnt<=0 (wrap).
- parity toggles on every cpu_clk.
- e_pulse and l_pulse are registered outputs. They are high for exactly the one clk after the qualifying cpu_clk edge and are never held across cycles.
- Mode 0 (4-step), events by cnt value at cpu_clk:
  - Q1_CYC: e.
  - Q2_CYC: e+l.
  - Q3_CYC: e.
  - M0_END-2: set irq.
  - M0_END-1: e+l, set irq.
  - M0_END: set irq, wrap to 0.
  - IRQ sets occur only when irq_inhibit=0.
- Mode 1 (5-step), events:
  - Q1_CYC: e.
  - Q2_CYC: e+l.
  - Q3_CYC: e.
  - M0_END-1: no event.
  - M1_END-1: e+l.
  - M1_END: wrap to 0.
  - Never sets irq.
- $4017 write (wren_4017=1):
  - mode<=from_cpu[7] and irq_inhibit<=from_cpu[6] immediately.
  - If from_cpu[6]=1, frame_irq<=0 in the same clk.
  - Loads the pending-reset delay: 3 cpu_clks if parity=0 at the write, 4 if parity=1.
- Pending reset expiry: on the cpu_clk that expires the delay, cnt<=0 and normal step decode is suppressed for that cycle. If mode=1, assert e_pulse and l_pulse for that cycle; if mode=0, no pulses.
- A second $4017 write while a reset is pending reloads the delay from the new parity; only one reset occurs.
- status_rd clears frame_irq. If status_rd and an irq-set event coincide in the same clk, the set wins and frame_irq=1.
- wren_4017 with from_cpu[6]=1 coincident with an irq-set event: the inhibit wins and frame_irq=0.
- Counter width: CNT_W must hold M1_END. cnt never exceeds the end value of the current mode. If the mode changes to 0 while cnt>M0_END, the block wraps at the next cpu_clk (cnt<=0, no events).
- rst asserted mid-frame or with a reset pending: all state returns to reset values on the next clk and the pending reset is discarded.

Decomposition:
- apu_pkg holds:
  - step constants Q1_CYC, Q2_CYC, Q3_CYC, M0_END, M1_END
  - typedef enum logic {FRAME_4STEP, FRAME_5STEP} frame_mode_t
  - typedef logic [CNT_W-1:0] frame_cnt_t
- One sub-module, apu_frame_reset_delay: a 3-bit down-counter implementing the parity-dependent pending-reset delay. It outputs a 1-clk expire strobe aligned to cpu_clk.

Test Plan:
- Free run after rst, mode 0, cpu_clk every 2 clks:
  - e_pulse at cnt 7456, 14912, 22370, 29828.
  - l_pulse at 14912 and 29828.
  - frame_irq rises at cnt 29827.
  - cnt returns to 0 after 29829; the 2nd frame repeats identically.
- Write $4017=0x80 (parity=0):
  - Exactly 3 cpu_clks later, e_pulse=l_pulse=1 and cnt=0.
  - e at 7456, e+l at 14912, e at 22370, e+l at 37280; wrap after 37281.
  - frame_irq stays 0.
- Write $4017=0x00 at parity=1: reset takes 4 cpu_clks, with no pulses at expiry. A second write 1 cpu_clk later restarts the delay, giving a single reset only.
- Mode 0 frame_irq=1, then status_rd: frame_irq=0 next clk. status_rd coincident with the cnt 29828 set: frame_irq stays 1.
- frame_irq=1, write $4017=0x40: frame_irq=0 the same clk and stays 0 through the next two frames.
- rst asserted with a reset pending at cnt 14000: cnt=0, mode=0, no pulses; first e_pulse at cnt 7456 after release.
